uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Frame-sequencing controller for the UART receiver. It sits between the RX line and the receive datapath: the data sampler, deserializer, start/parity/stop checkers. It owns the oversampling edge counter and the bit counter, and walks the frame START → DATA → PARITY → STOP. It issues per-phase enables to each datapath unit, collects their error flags and emits a one-cycle `Data_Valid` for error-free frames.

## Interface
Parameters:
- `WIDTH`, 8, data bits per frame.
- `PRESCALE_WIDTH`, 6, width of `Prescale`/`Edge_Cnt`.

Ports:
- `CLK`  in  1  oversampling clock; the only clock.
- `RST`  in  1  asynchronous, active-high reset.
- `RX_IN`  in  1  serial line, idle high.
- `PAR_EN`  in  1  parity bit present.
- `Prescale`  in  PRESCALE_WIDTH  oversampling ratio; legal values are 8, 16, 32.
- `Strt_Glitch`  in  1  registered flag from the start checker.
- `Par_Err`  in  1  registered flag from the parity checker.
- `Stp_Err`  in  1  registered flag from the stop checker.
- `Edge_Cnt`  out  PRESCALE_WIDTH  oversample index within the current bit.
- `Bit_Cnt`  out  $clog2(WIDTH+1)  data-bit index.
- `Dat_Samp_En`  out  1  sampler enable.
- `Deser_En`  out  1  deserializer enable.
- `Strt_Chk_En` / `Par_Chk_En` / `Stp_Chk_En`  out  1  checker enables.
- `Data_Valid`  out  1  one-cycle pulse marking a good frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- End-of-bit (EOB) is the cycle where `Edge_Cnt == Prescale_q-1`.
- IDLE
  - `Edge_Cnt` and `Bit_Cnt` are held at 0.
  - `RX_IN==0` → START.
  - On that same edge, `Prescale` is latched into `Prescale_q` and `PAR_EN` into `par_en_q`. Both are frozen for the whole frame.
- Counters, in every state other than IDLE:
  - `Edge_Cnt` increments each cycle and wraps to 0 after EOB.
  - `Bit_Cnt` increments on EOB in DATA only.
  - `Bit_Cnt` clears when entering DATA and when entering IDLE.
- START
  - `Strt_Chk_En=1` for the whole state.
  - At EOB: `Strt_Glitch` → IDLE; otherwise → DATA.
- DATA
  - `Deser_En=1` for the whole state.
  - At EOB with `Bit_Cnt==WIDTH-1`: → PARITY if `par_en_q`, else → STOP.
- PARITY
  - `Par_Chk_En=1` for the whole state.
  - At EOB, `Par_Err` is captured into `par_err_q`; → STOP.
- STOP
  - `Stp_Chk_En=1` for the whole state.
  - At EOB: `Data_Valid` is driven high for the following single cycle iff `!par_err_q && !Stp_Err`; → IDLE.
- `Dat_Samp_En=1` in every state except IDLE.
- `par_err_q` clears on entry to START.
- A frame rejected by an error returns to IDLE silently; no `Data_Valid`.
- Illegal state encoding → IDLE.

## Timing
- Reset values: state IDLE, all outputs 0, `Edge_Cnt=0`, `Bit_Cnt=0`, `par_err_q=0`.
- `RST` asserted mid-frame aborts the frame immediately; no `Data_Valid` follows.
- All outputs are registered or decoded from registered state. The enables change on the same edge as the state.
- Checkers sample at `Edge_Cnt == Prescale_q/2 + 2` and present flags one cycle later. The controller reads those flags only at EOB, so the flags are always settled.
- Frame length without parity, from the first IDLE-low cycle: `(WIDTH+2)*Prescale_q` cycles.
- `Data_Valid` rises on the cycle after the STOP EOB, while the state is already IDLE.
- `RX_IN` low on the first IDLE cycle after STOP starts the next frame on that edge. Back-to-back frames therefore incur zero gap cycles.
- A `Prescale` change mid-frame has no effect until the next IDLE→START transition.

## Configuration
- Macro: `UART_RX_BREAK_DET_EN`.
- When defined:
  - Adds input `P_DATA[WIDTH-1:0]`, output `Break_Det`, and state BREAK.
  - At STOP EOB, if `Stp_Err && P_DATA==0`: pulse `Break_Det` for 1 cycle, suppress `Data_Valid`, → BREAK.
  - BREAK holds all enables at 0 until `RX_IN==1`, then → IDLE.
- When undefined: no BREAK state and no extra ports. An all-zero frame is handled as an ordinary stop error.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum, IDLE=0 through STOP=4, plus BREAK=5;
  - the constants `PRESCALE_MIN=8` and `CHK_OFFSET=2`.
- One sub-module, `uart_rx_edge_bit_cnt`:
  - inputs: `CLK`, `RST`, `cnt_en`, `bit_inc`, `bit_clr`, `Prescale_q`;
  - outputs: `Edge_Cnt`, `Bit_Cnt`, `eob`.
- The FSM and enable decode stay in `uart_rx_ctrl`.

## Test plan
- **Good frame:** `Prescale=8`, `PAR_EN=0`, send 0xA5, all flags 0 → `Data_Valid` pulses exactly once, 80 cycles after the start edge; `Deser_En` is high for 64 cycles.
- **Parity error:** `Prescale=16`, `PAR_EN=1`, `Par_Err=1` during PARITY → STOP is still traversed, no `Data_Valid`, IDLE after 176 cycles.
- **Start glitch:** `RX_IN` low for 3 cycles, `Strt_Glitch=1` at START EOB → IDLE after 8 cycles; `Deser_En` never asserted.
- **Back-to-back frames:** `Prescale=32`, two frames with zero idle gap → two `Data_Valid` pulses exactly 320 cycles apart.
- **Mid-frame reset:** `RST` pulsed while `Bit_Cnt=4` in DATA → all outputs 0 on the same cycle, no `Data_Valid`; the next frame is received normally.
- **Break detection:** with `UART_RX_BREAK_DET_EN` defined, `RX_IN` held low for 20 bit times → `Break_Det` pulses once, the FSM stays in BREAK until `RX_IN` returns high, then goes to IDLE.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive controller.
// Defines the frame-sequencer state encoding and the oversampling constants.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_e;

    localparam int PRESCALE_MIN = 8;
    localparam int CHK_OFFSET   = 2;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversample edge counter and data-bit counter.
// eob flags the last oversample of the current bit while counting is enabled.
module uart_rx_edge_bit_cnt #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        cnt_en,
    input  logic                        bit_inc,
    input  logic                        bit_clr,
    input  logic [PRESCALE_WIDTH-1:0]   Prescale_q,
    output logic [PRESCALE_WIDTH-1:0]   Edge_Cnt,
    output logic [$clog2(WIDTH+1)-1:0]  Bit_Cnt,
    output logic                        eob
);
    localparam int BW = $clog2(WIDTH + 1);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;

    assign eob = cnt_en && (edge_cnt_q == Prescale_q - PRESCALE_WIDTH'(1));

    always_comb begin
        if (!cnt_en || eob) edge_cnt_d = '0;
        else                edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);

        bit_cnt_d = bit_cnt_q;
        if (bit_clr)      bit_cnt_d = '0;
        else if (bit_inc) bit_cnt_d = bit_cnt_q + BW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign Edge_Cnt = edge_cnt_q;
    assign Bit_Cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer (START/DATA/PARITY/STOP) with datapath enables.
// Break detection (BREAK state, P_DATA/Break_Det ports) is built only with UART_RX_BREAK_DET_EN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        RX_IN,
    input  logic                        PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0]   Prescale,
    input  logic                        Strt_Glitch,
    input  logic                        Par_Err,
    input  logic                        Stp_Err,
    output logic [PRESCALE_WIDTH-1:0]   Edge_Cnt,
    output logic [$clog2(WIDTH+1)-1:0]  Bit_Cnt,
    output logic                        Dat_Samp_En,
    output logic                        Deser_En,
    output logic                        Strt_Chk_En,
    output logic                        Par_Chk_En,
    output logic                        Stp_Chk_En,
    output logic                        Data_Valid
`ifdef UART_RX_BREAK_DET_EN
    ,
    input  logic [WIDTH-1:0]            P_DATA,
    output logic                        Break_Det
`endif
);
    localparam int BW = $clog2(WIDTH + 1);

    state_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q, par_err_q;
    logic                      samp_en_q, deser_en_q, strt_en_q, par_chk_q, stp_en_q, data_valid_q;
    logic                      start_det, cnt_en, bit_inc, bit_clr, eob, bit_last, brk;

    // The IDLE cycle that sees RX low already counts as oversample 0 of the start bit,
    // which is what gives zero-gap back-to-back frames.
    assign start_det = (state_q == IDLE) && !RX_IN;
    assign cnt_en    = start_det || (state_q inside {START, DATA, PARITY, STOP});
    assign bit_inc   = (state_q == DATA) && eob;
    assign bit_clr   = ((state_d == DATA) && (state_q != DATA)) ||
                       ((state_d == IDLE) && (state_q != IDLE));
    assign bit_last  = (Bit_Cnt == BW'(WIDTH - 1));

`ifdef UART_RX_BREAK_DET_EN
    logic break_det_q;
    assign brk       = Stp_Err && (P_DATA == '0);
    assign Break_Det = break_det_q;
`else
    assign brk       = 1'b0;
`endif

    uart_rx_edge_bit_cnt #(
        .WIDTH          (WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .cnt_en     (cnt_en),
        .bit_inc    (bit_inc),
        .bit_clr    (bit_clr),
        .Prescale_q (prescale_q),
        .Edge_Cnt   (Edge_Cnt),
        .Bit_Cnt    (Bit_Cnt),
        .eob        (eob)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!RX_IN) state_d = START;
            START:  if (eob) state_d = Strt_Glitch ? IDLE : DATA;
            DATA:   if (eob && bit_last) state_d = par_en_q ? PARITY : STOP;
            PARITY: if (eob) state_d = STOP;
            STOP:   if (eob) state_d = brk ? BREAK : IDLE;
`ifdef UART_RX_BREAK_DET_EN
            BREAK:  if (RX_IN) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_err_q    <= 1'b0;
            samp_en_q    <= 1'b0;
            deser_en_q   <= 1'b0;
            strt_en_q    <= 1'b0;
            par_chk_q    <= 1'b0;
            stp_en_q     <= 1'b0;
            data_valid_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (start_det) begin
                prescale_q <= Prescale;
                par_en_q   <= PAR_EN;
                par_err_q  <= 1'b0;
            end else if ((state_q == PARITY) && eob) begin
                par_err_q  <= Par_Err;
            end
            samp_en_q    <= state_d inside {START, DATA, PARITY, STOP};
            deser_en_q   <= (state_d == DATA);
            strt_en_q    <= (state_d == START);
            par_chk_q    <= (state_d == PARITY);
            stp_en_q     <= (state_d == STOP);
            data_valid_q <= (state_q == STOP) && eob && !par_err_q && !Stp_Err && !brk;
`ifdef UART_RX_BREAK_DET_EN
            break_det_q  <= (state_q == STOP) && eob && brk;
`endif
        end
    end

    assign Dat_Samp_En = samp_en_q;
    assign Deser_En    = deser_en_q;
    assign Strt_Chk_En = strt_en_q;
    assign Par_Chk_En  = par_chk_q;
    assign Stp_Chk_En  = stp_en_q;
    assign Data_Valid  = data_valid_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed, table-driven bench for uart_rx_ctrl.
// Break-detection sequence is included when UART_RX_BREAK_DET_EN is defined.
module tb_uart_rx_ctrl;
    localparam int WIDTH = 8;
    localparam int PW    = 6;
    localparam int BW    = $clog2(WIDTH + 1);

    logic          CLK, RST, RX_IN, PAR_EN, Strt_Glitch, Par_Err, Stp_Err;
    logic [PW-1:0] Prescale;
    logic [PW-1:0] Edge_Cnt;
    logic [BW-1:0] Bit_Cnt;
    logic          Dat_Samp_En, Deser_En, Strt_Chk_En, Par_Chk_En, Stp_Chk_En, Data_Valid;
`ifdef UART_RX_BREAK_DET_EN
    logic [WIDTH-1:0] P_DATA;
    logic             Break_Det;
`endif

    uart_rx_ctrl #(.WIDTH(WIDTH), .PRESCALE_WIDTH(PW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .Strt_Glitch (Strt_Glitch),
        .Par_Err     (Par_Err),
        .Stp_Err     (Stp_Err),
        .Edge_Cnt    (Edge_Cnt),
        .Bit_Cnt     (Bit_Cnt),
        .Dat_Samp_En (Dat_Samp_En),
        .Deser_En    (Deser_En),
        .Strt_Chk_En (Strt_Chk_En),
        .Par_Chk_En  (Par_Chk_En),
        .Stp_Chk_En  (Stp_Chk_En),
        .Data_Valid  (Data_Valid)
`ifdef UART_RX_BREAK_DET_EN
        ,
        .P_DATA      (P_DATA),
        .Break_Det   (Break_Det)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0, dv_cnt = 0, dv_last = 0, dv_prev = 0;
    int samp_cnt = 0, deser_cnt = 0, strt_cnt = 0, par_cnt = 0, stp_cnt = 0;
    int brk_cnt = 0, brk_last = 0;
    int tests = 0, fails = 0;

    // Activity monitor, sampled just after each rising edge.
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (Data_Valid) begin dv_cnt++; dv_prev = dv_last; dv_last = cyc; end
        if (Dat_Samp_En) samp_cnt++;
        if (Deser_En)    deser_cnt++;
        if (Strt_Chk_En) strt_cnt++;
        if (Par_Chk_En)  par_cnt++;
        if (Stp_Chk_En)  stp_cnt++;
`ifdef UART_RX_BREAK_DET_EN
        if (Break_Det) begin brk_cnt++; brk_last = cyc; end
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            RX_IN = 1'b1; Strt_Glitch = 1'b0; Par_Err = 1'b0; Stp_Err = 1'b0;
        end
    endtask

    // Drives one frame starting with the IDLE-low cycle; a glitch frame is 3 low cycles then high.
    task automatic drive_frame(input int p, input bit pe, input logic [7:0] d, input bit glitch,
                               input bit gf, input bit perr, input bit serr, output int t_fall);
        logic [10:0] bits;
        int nb;
        bits = {1'b1, ^d, d, 1'b0};
        if (!pe) bits[9] = 1'b1;
        nb = glitch ? 1 : (pe ? 11 : 10);
        t_fall = 0;
        for (int c = 0; c < nb * p; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                t_fall = cyc; Prescale = PW'(p); PAR_EN = pe;
                Strt_Glitch = gf; Par_Err = perr; Stp_Err = serr;
            end else if (c == 1) begin
                Prescale = (p == 8) ? 6'd16 : 6'd8;
                PAR_EN   = !pe;
            end
            RX_IN = glitch ? (c >= 3) : bits[c / p];
        end
    endtask

    typedef struct {
        int         p;
        bit         pe;
        logic [7:0] d;
        bit         glitch;
        bit         gf;
        bit         perr;
        bit         serr;
        int         exp_dv;
        int         exp_lat;
        int         exp_samp;
        int         exp_deser;
        int         exp_strt;
        int         exp_par;
        int         exp_stp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int t_fall, b_dv, b_samp, b_deser, b_strt, b_par, b_stp, b_brk;
        bit found;

        //                p  pe  data  gl gf pe se dv lat  samp deser strt par stp
        vecs[0] = '{8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1, 80,  79,  64,  7,  0,  8};
        vecs[1] = '{16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0,   175, 128, 15, 16, 16};
        vecs[2] = '{8,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0,   7,   0,   7,  0,  0};
        vecs[3] = '{16, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1, 176, 175, 128, 15, 16, 16};
        vecs[4] = '{32, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0,   319, 256, 31, 0,  32};
        vecs[5] = '{8,  1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 88,  87,  64,  7,  8,  8};
        vecs[6] = '{32, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1, 352, 351, 256, 31, 32, 32};

        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
        Strt_Glitch = 1'b0; Par_Err = 1'b0; Stp_Err = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        P_DATA = 8'hA5;
`endif
        repeat (3) @(negedge CLK);
        chk("reset Edge_Cnt", Edge_Cnt, 0);
        chk("reset Bit_Cnt", Bit_Cnt, 0);
        chk("reset Dat_Samp_En", Dat_Samp_En, 0);
        chk("reset Deser_En", Deser_En, 0);
        chk("reset Strt_Chk_En", Strt_Chk_En, 0);
        chk("reset Par_Chk_En", Par_Chk_En, 0);
        chk("reset Stp_Chk_En", Stp_Chk_En, 0);
        chk("reset Data_Valid", Data_Valid, 0);
        RST = 1'b0;
        idle(3);

        foreach (vecs[i]) begin
            b_dv = dv_cnt; b_samp = samp_cnt; b_deser = deser_cnt;
            b_strt = strt_cnt; b_par = par_cnt; b_stp = stp_cnt;
            drive_frame(vecs[i].p, vecs[i].pe, vecs[i].d, vecs[i].glitch,
                        vecs[i].gf, vecs[i].perr, vecs[i].serr, t_fall);
            idle(4);
            chk($sformatf("v%0d dv_count", i), dv_cnt - b_dv, vecs[i].exp_dv);
            chk($sformatf("v%0d samp_cycles", i), samp_cnt - b_samp, vecs[i].exp_samp);
            chk($sformatf("v%0d deser_cycles", i), deser_cnt - b_deser, vecs[i].exp_deser);
            chk($sformatf("v%0d strt_cycles", i), strt_cnt - b_strt, vecs[i].exp_strt);
            chk($sformatf("v%0d par_cycles", i), par_cnt - b_par, vecs[i].exp_par);
            chk($sformatf("v%0d stp_cycles", i), stp_cnt - b_stp, vecs[i].exp_stp);
            chk($sformatf("v%0d idle_after", i), Dat_Samp_En, 0);
            if (vecs[i].exp_dv != 0)
                chk($sformatf("v%0d dv_latency", i), dv_last - t_fall, vecs[i].exp_lat);
        end

        // Back-to-back frames at Prescale=32 with no idle gap.
        b_dv = dv_cnt; b_deser = deser_cnt;
        drive_frame(32, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, t_fall);
        drive_frame(32, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, t_fall);
        idle(4);
        chk("b2b dv_count", dv_cnt - b_dv, 2);
        chk("b2b dv_spacing", dv_last - dv_prev, 320);
        chk("b2b second_latency", dv_last - t_fall, 320);
        chk("b2b deser_cycles", deser_cnt - b_deser, 512);

        // Mid-frame reset once Bit_Cnt reaches 4.
        b_dv = dv_cnt; found = 1'b0; t_fall = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge CLK);
            if (c == 0) begin t_fall = cyc; Prescale = 6'd8; PAR_EN = 1'b0; end
            if (c > 0 && Bit_Cnt == BW'(4)) found = 1'b1;
            else RX_IN = (c / 8 == 0) ? 1'b0 : 1'b1;
        end
        chk("midrst reached Bit_Cnt=4", found, 1);
        chk("midrst bitcnt4_time", cyc - t_fall, 40);
        chk("midrst Edge_Cnt", Edge_Cnt, 0);
        chk("midrst Deser_En before", Deser_En, 1);
        #2 RST = 1'b1;
        #1;
        chk("midrst Dat_Samp_En", Dat_Samp_En, 0);
        chk("midrst Deser_En", Deser_En, 0);
        chk("midrst Bit_Cnt", Bit_Cnt, 0);
        chk("midrst Edge_Cnt after", Edge_Cnt, 0);
        @(negedge CLK);
        RST = 1'b0; RX_IN = 1'b1;
        idle(100);
        chk("midrst no_dv", dv_cnt - b_dv, 0);
        b_dv = dv_cnt;
        drive_frame(8, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, t_fall);
        idle(4);
        chk("postrst dv_count", dv_cnt - b_dv, 1);
        chk("postrst dv_latency", dv_last - t_fall, 80);

`ifdef UART_RX_BREAK_DET_EN
        // RX held low for 20 bit times with an all-zero word and a stop error.
        b_dv = dv_cnt; b_samp = samp_cnt; b_brk = brk_cnt; t_fall = 0;
        P_DATA = 8'h00;
        for (int c = 0; c < 160; c++) begin
            @(negedge CLK);
            if (c == 0) begin t_fall = cyc; Prescale = 6'd8; PAR_EN = 1'b0; Stp_Err = 1'b1; end
            if (c == 150) chk("brk hold Dat_Samp_En", Dat_Samp_En, 0);
            RX_IN = 1'b0;
        end
        idle(5);
        P_DATA = 8'hA5;
        chk("brk pulse_count", brk_cnt - b_brk, 1);
        chk("brk pulse_time", brk_last - t_fall, 80);
        chk("brk no_dv", dv_cnt - b_dv, 0);
        chk("brk samp_cycles", samp_cnt - b_samp, 79);
        b_dv = dv_cnt;
        drive_frame(8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, t_fall);
        idle(4);
        chk("postbrk dv_count", dv_cnt - b_dv, 1);
        chk("postbrk dv_latency", dv_last - t_fall, 80);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
